// File: rtl/fxp2flt_pkg.sv
// Shared types and elaboration helpers for the fixed-point to float converter.
package fxp2flt_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StNorm = 2'd1,
        StPack = 2'd2
    } fxp2flt_state_e;

    function automatic int unsigned bias(input int unsigned ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int unsigned flt_width(input int unsigned ew, input int unsigned mw);
        return 1 + ew + mw;
    endfunction

endpackage

// File: rtl/fxp2flt_round.sv
// Round-to-nearest-even on a normalized mantissa; a carry out bumps the exponent.
module fxp2flt_round #(
    parameter int unsigned EW = 5,
    parameter int unsigned MW = 10
) (
    input  logic [MW-1:0] i_mant,
    input  logic [EW-1:0] i_exp,
    input  logic          i_guard,
    input  logic          i_sticky,
    output logic [MW-1:0] o_mant,
    output logic [EW-1:0] o_exp
);

    logic          w_round_up;
    logic [MW:0]   w_sum;

    // Ties go up only when the kept LSB is odd.
    assign w_round_up = i_guard & (i_sticky | i_mant[0]);
    assign w_sum      = {1'b0, i_mant} + {{MW{1'b0}}, w_round_up};
    assign o_mant     = w_sum[MW-1:0];
    assign o_exp      = i_exp + {{(EW-1){1'b0}}, w_sum[MW]};

endmodule

// File: rtl/fxp2flt_conv.sv
// Iterative signed fixed-point (IW.FW) to float (EW/MW) converter, one shift per cycle.
// Define FXP2FLT_RNE_EN to round to nearest even instead of truncating.
module fxp2flt_conv
    import fxp2flt_pkg::*;
#(
    parameter int unsigned IW = 8,
    parameter int unsigned FW = 8,
    parameter int unsigned EW = 5,
    parameter int unsigned MW = 10
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [IW+FW-1:0]              fxp_in,
    output logic [flt_width(EW, MW)-1:0]  flt_out,
    output logic                          ack,
    output logic                          busy
);

    localparam int unsigned W    = IW + FW;
    localparam int unsigned BIAS = bias(EW);
    localparam int unsigned OW   = flt_width(EW, MW);
    localparam logic [EW-1:0] ExpInit = EW'(IW - 1 + BIAS);

    if (!((int'(BIAS) - int'(FW)) >= 1 && (IW - 1 + BIAS) <= ((1 << EW) - 2))) begin : g_range_err
        $error("fxp2flt_conv: exponent range cannot represent every input magnitude");
    end

    fxp2flt_state_e r_state, w_state_nxt;
    logic           r_start_q;
    logic           r_sign;
    logic [W-1:0]   r_mag;
    logic [EW-1:0]  r_expc;
    logic [OW-1:0]  r_flt;

    logic           w_accept;
    logic [MW-1:0]  w_mant;
    logic [MW-1:0]  w_mant_out;
    logic [EW-1:0]  w_exp_out;

    assign w_accept = start & ~r_start_q & (r_state == StIdle);

`ifdef FXP2FLT_RNE_EN
    // Bits below the hidden one, right-padded so narrow inputs still fill the mantissa.
    logic [W-2+MW:0] w_ext;
    logic            w_guard;
    logic            w_sticky;

    assign w_ext    = {r_mag[W-2:0], {MW{1'b0}}};
    assign w_mant   = w_ext[W-2+MW -: MW];
    assign w_guard  = w_ext[W-2];
    assign w_sticky = |w_ext[W-3:0];

    fxp2flt_round #(
        .EW (EW),
        .MW (MW)
    ) u_round (
        .i_mant   (w_mant),
        .i_exp    (r_expc),
        .i_guard  (w_guard),
        .i_sticky (w_sticky),
        .o_mant   (w_mant_out),
        .o_exp    (w_exp_out)
    );
`else
    assign w_mant     = MW'({r_mag[W-2:0], {MW{1'b0}}} >> (W - 1));
    assign w_mant_out = w_mant;
    assign w_exp_out  = r_expc;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StNorm;
            StNorm:  if ((r_mag == '0) || r_mag[W-1]) w_state_nxt = StPack;
            StPack:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_start_q <= 1'b0;
            r_sign    <= 1'b0;
            r_mag     <= '0;
            r_expc    <= '0;
            r_flt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_q <= start;
            if (w_accept) begin
                r_sign <= fxp_in[W-1];
                r_mag  <= fxp_in[W-1] ? (~fxp_in + W'(1)) : fxp_in;
                r_expc <= ExpInit;
            end else if (r_state == StNorm) begin
                // The result register is loaded on the edge entering PACK so it is valid with ack.
                if (r_mag == '0) begin
                    r_flt <= '0;
                end else if (r_mag[W-1]) begin
                    r_flt <= {r_sign, w_exp_out, w_mant_out};
                end else begin
                    r_mag  <= r_mag << 1;
                    r_expc <= r_expc - EW'(1);
                end
            end
        end
    end

    assign flt_out = r_flt;
    assign ack     = (r_state == StPack);
    assign busy    = (r_state == StNorm);

endmodule

// File: tb/tb_fxp2flt_conv.sv
// Directed and random checks of fxp2flt_conv at default and wide parameter sets.
module tb_fxp2flt_conv;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_start, b_start;
    logic [15:0] a_fxp, b_fxp;
    logic [15:0] a_flt;
    logic [20:0] b_flt;
    logic        a_ack, a_busy, b_ack, b_busy;

    always #5 clk = ~clk;

    fxp2flt_conv u_dut_a (
        .clk     (clk),
        .reset   (reset),
        .start   (a_start),
        .fxp_in  (a_fxp),
        .flt_out (a_flt),
        .ack     (a_ack),
        .busy    (a_busy)
    );

    fxp2flt_conv #(
        .IW (4),
        .FW (12),
        .EW (6),
        .MW (14)
    ) u_dut_b (
        .clk     (clk),
        .reset   (reset),
        .start   (b_start),
        .fxp_in  (b_fxp),
        .flt_out (b_flt),
        .ack     (b_ack),
        .busy    (b_busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Mathematical reference: locate the leading one, scale the remainder to MW bits.
    function automatic logic [63:0] model(input longint x, input int iw, input int fw,
                                          input int ew, input int mw);
        longint w, sign, m, p, e, frac;
`ifdef FXP2FLT_RNE_EN
        longint rem, half;
`endif
        w    = iw + fw;
        sign = (x >> (w - 1)) & 1;
        m    = (sign != 0) ? ((longint'(1) << w) - x) : x;
        if (m == 0) return 64'd0;
        p = w - 1;
        while (((m >> p) & 1) == 0) p--;
        e    = p - fw + ((longint'(1) << (ew - 1)) - 1);
        frac = m - (longint'(1) << p);
        if (p > mw) begin
`ifdef FXP2FLT_RNE_EN
            rem  = frac & ((longint'(1) << (p - mw)) - 1);
            half = longint'(1) << (p - mw - 1);
            frac = frac >> (p - mw);
            if (rem > half || (rem == half && (frac & 1) == 1)) frac++;
            if (frac == (longint'(1) << mw)) begin
                frac = 0;
                e++;
            end
`else
            frac = frac >> (p - mw);
`endif
        end else begin
            frac = frac << (mw - p);
        end
        return 64'((sign << (ew + mw)) | (e << mw) | frac);
    endfunction

    // Accept edge counts as edge 1; zero input finishes in 2.
    function automatic int exp_lat(input logic [15:0] x);
        logic [15:0] m;
        int          lz;
        m = x[15] ? (~x + 16'd1) : x;
        if (m == 16'd0) return 2;
        lz = 0;
        while (m[15] == 1'b0) begin
            m = m << 1;
            lz++;
        end
        return 2 + lz;
    endfunction

    task automatic convert(input bit sel, input logic [15:0] x, output int lat,
                           output logic [63:0] res, output bit busy_ok);
        @(negedge clk);
        if (sel) begin
            b_fxp = x; b_start = 1'b1;
        end else begin
            a_fxp = x; a_start = 1'b1;
        end
        @(posedge clk);
        lat     = 1;
        busy_ok = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        b_start = 1'b0;
        while (!(sel ? b_ack : a_ack) && lat < 40) begin
            if (!(sel ? b_busy : a_busy)) busy_ok = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = sel ? 64'(b_flt) : 64'(a_flt);
    endtask

    initial begin
        int          lat, n_ack;
        logic [63:0] res;
        bit          bok, hold_ok;
        logic [15:0] x;

        reset = 1'b0; a_start = 1'b0; b_start = 1'b0; a_fxp = '0; b_fxp = '0;
        repeat (3) @(negedge clk);
        check("reset_flt_a", 64'(a_flt), 64'h0);
        check("reset_ack_a", 64'(a_ack), 64'h0);
        check("reset_busy_a", 64'(a_busy), 64'h0);
        check("reset_flt_b", 64'(b_flt), 64'h0);
        reset = 1'b1;
        @(negedge clk);

        convert(0, 16'h0001, lat, res, bok);
        check("one_res", res, 64'h1C00);
        check("one_lat", 64'(lat), 64'd17);
        check("one_busy", 64'(bok), 64'd1);
        check("busy_low_at_ack", 64'(a_busy), 64'd0);

        convert(0, 16'h0030, lat, res, bok);
        check("p30_res", res, 64'h3200);
        check("p30_lat", 64'(lat), 64'd12);
        convert(0, 16'hFFD0, lat, res, bok);
        check("m30_res", res, 64'hB200);
        convert(0, 16'h0000, lat, res, bok);
        check("zero_res", res, 64'h0);
        check("zero_lat", 64'(lat), 64'd2);
        convert(0, 16'h7FFF, lat, res, bok);
`ifdef FXP2FLT_RNE_EN
        check("max_res", res, 64'h5800);
`else
        check("max_res", res, 64'h57FF);
`endif
        convert(0, 16'h8000, lat, res, bok);
        check("min_res", res, 64'hD800);
        check("min_lat", 64'(lat), 64'd2);
        convert(0, 16'hFFFF, lat, res, bok);
        check("neg1_res", res, 64'h9C00);

        // start held for three cycles must give one conversion
        @(negedge clk);
        a_fxp = 16'h0100; a_start = 1'b1; n_ack = 0;
        repeat (3) begin
            @(negedge clk);
            if (a_ack) n_ack++;
        end
        a_start = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (a_ack) n_ack++;
        end
        check("hold_acks", 64'(n_ack), 64'd1);
        check("hold_res", 64'(a_flt), 64'h3C00);

        // start edge during NORM is ignored and the old result stays put
        @(negedge clk);
        a_fxp = 16'h0001; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (3) @(negedge clk);
        a_fxp = 16'h0100; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        hold_ok = 1'b1; lat = 0;
        while (!a_ack && lat < 40) begin
            if (a_flt !== 16'h3C00) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("midnorm_hold", 64'(hold_ok), 64'd1);
        check("midnorm_res", 64'(a_flt), 64'h1C00);
        n_ack = 0;
        repeat (25) begin
            @(negedge clk);
            if (a_ack) n_ack++;
        end
        check("midnorm_no_extra_ack", 64'(n_ack), 64'd0);

        // asynchronous reset in the middle of normalization
        @(negedge clk);
        a_fxp = 16'h0001; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_pre_busy", 64'(a_busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_flt", 64'(a_flt), 64'h0);
        check("rst_async_busy", 64'(a_busy), 64'd0);
        check("rst_async_ack", 64'(a_ack), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        n_ack = 0;
        repeat (25) begin
            @(negedge clk);
            if (a_ack) n_ack++;
        end
        check("rst_no_ack", 64'(n_ack), 64'd0);
        convert(0, 16'h0001, lat, res, bok);
        check("rst_restart_res", res, 64'h1C00);
        check("rst_restart_lat", 64'(lat), 64'd17);

        // wide configuration: IW=4 FW=12 EW=6 MW=14
        convert(1, 16'h0001, lat, res, bok);
        check("b_one_res", res, 64'h4C000);
        check("b_one_lat", 64'(lat), 64'd17);
        convert(1, 16'h7FFF, lat, res, bok);
        check("b_max_res", res, 64'h87FFF);
        convert(1, 16'h8000, lat, res, bok);
        check("b_min_res", res, 64'h188000);
        convert(1, 16'h0000, lat, res, bok);
        check("b_zero_res", res, 64'h0);

        for (int i = 0; i < 120; i++) begin
            x = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) x = -x;
            convert(0, x, lat, res, bok);
            check("rand_a_res", res, model(longint'(x), 8, 8, 5, 10));
            check("rand_a_lat", 64'(lat), 64'(exp_lat(x)));
        end
        for (int i = 0; i < 120; i++) begin
            x = 16'($urandom) >> $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) x = -x;
            convert(1, x, lat, res, bok);
            check("rand_b_res", res, model(longint'(x), 4, 12, 6, 14));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d passed of %0d",
                 n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
